// File: rtl/bus_host_pkg.sv
// ---------------------------------------------------------------------------
// bus_host_pkg : shared state encoding and idle bus value for bus_host
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bus_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TX        = 3'd1,
    ST_TURN      = 3'd2,
    ST_RX        = 3'd3,
    ST_TURN_BACK = 3'd4
  } state_e;

  localparam logic [7:0] IDLE_BYTE = 8'h00;

endpackage

`default_nettype wire

// File: rtl/bus_host_fifo.sv
// ---------------------------------------------------------------------------
// bus_host_fifo : synchronous FIFO with push/pop, full/empty and occupancy
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_host_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop_ok) begin
      rptr_d = rptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_host.sv
// ---------------------------------------------------------------------------
// bus_host : host end of a turnaround data bus (TX burst, turn, RX, turn back)
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_host
  import bus_host_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tx_valid_i,
  input  logic [7:0]       tx_data_i,
  output logic             tx_ready_o,
  input  logic             start_i,
  input  logic [LEN_W-1:0] rx_len_i,
  output logic             busy_o,
  output logic             rx_valid_o,
  output logic [7:0]       rx_data_o,
  output logic             done_o,
  output logic             tx_oe,
  inout  wire  [7:0]       data_io
);

  localparam int TW = $clog2(FIFO_DEPTH) + 1;

  state_e           state_q, state_d;
  logic [TW-1:0]    tx_rem_q, tx_rem_d;
  logic [LEN_W-1:0] rx_rem_q, rx_rem_d;
  logic [7:0]       drv_q, drv_d;
  logic             tx_oe_q, tx_oe_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             done_q, done_d;

  logic             fifo_pop;
  logic [7:0]       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [TW-1:0]    fifo_count;

  bus_host_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (tx_valid_i),
    .data_i  (tx_data_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Host drive is gated by the registered direction line itself, so the two
  // can never disagree.
  assign data_io    = tx_oe_q ? 8'bz : drv_q;
  assign tx_oe      = tx_oe_q;
  assign tx_ready_o = !fifo_full;
  assign busy_o     = (state_q != ST_IDLE);
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
  assign done_o     = done_q;

  always_comb begin
    state_d    = state_q;
    tx_rem_d   = tx_rem_q;
    rx_rem_d   = rx_rem_q;
    drv_d      = drv_q;
    tx_oe_d    = tx_oe_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    done_d     = 1'b0;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          rx_rem_d = rx_len_i;
          // Byte 0 is loaded on the start edge; tx_rem counts the bytes still queued behind it.
          if (fifo_count != '0 && !fifo_empty) begin
            fifo_pop = 1'b1;
            drv_d    = fifo_head;
            tx_rem_d = fifo_count - TW'(1);
            state_d  = ST_TX;
          end else if (rx_len_i != '0) begin
            tx_oe_d = 1'b1;
            state_d = ST_TURN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_TX: begin
        if (tx_rem_q != '0) begin
          fifo_pop = 1'b1;
          drv_d    = fifo_head;
          tx_rem_d = tx_rem_q - TW'(1);
        end else begin
          drv_d = IDLE_BYTE;
          if (rx_rem_q != '0) begin
            tx_oe_d = 1'b1;
            state_d = ST_TURN;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_TURN: begin
        state_d = ST_RX;
      end
      ST_RX: begin
        rx_valid_d = 1'b1;
        rx_data_d  = data_io;
        rx_rem_d   = rx_rem_q - LEN_W'(1);
        if (rx_rem_q == LEN_W'(1)) begin
          state_d = ST_TURN_BACK;
        end
      end
      ST_TURN_BACK: begin
        tx_oe_d = 1'b0;
        drv_d   = IDLE_BYTE;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        tx_oe_d = 1'b0;
        drv_d   = IDLE_BYTE;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      tx_rem_q   <= '0;
      rx_rem_q   <= '0;
      drv_q      <= IDLE_BYTE;
      tx_oe_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_rem_q   <= tx_rem_d;
      rx_rem_q   <= rx_rem_d;
      drv_q      <= drv_d;
      tx_oe_q    <= tx_oe_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      done_q     <= done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_host.sv
// ---------------------------------------------------------------------------
// tb_bus_host : directed self-checking bench for bus_host with a Device model
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bus_host;

  logic       clk_i;
  logic       rst_ni;
  logic       tx_valid_i;
  logic [7:0] tx_data_i;
  logic       tx_ready_o;
  logic       start_i;
  logic [7:0] rx_len_i;
  logic       busy_o;
  logic       rx_valid_o;
  logic [7:0] rx_data_o;
  logic       done_o;
  logic       tx_oe;
  wire  [7:0] data_io;

  logic       dev_drive;
  logic [7:0] dev_val;
  logic [7:0] dev_bytes [8];
  int         dev_len;
  int         dev_cyc;

  int n_checks;
  int n_errors;

  // Device releases combinationally as soon as the host reclaims the bus.
  assign data_io = (dev_drive && tx_oe) ? dev_val : 8'bz;

  bus_host #(
    .FIFO_DEPTH (8),
    .LEN_W      (8)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .tx_valid_i (tx_valid_i),
    .tx_data_i  (tx_data_i),
    .tx_ready_o (tx_ready_o),
    .start_i    (start_i),
    .rx_len_i   (rx_len_i),
    .busy_o     (busy_o),
    .rx_valid_o (rx_valid_o),
    .rx_data_o  (rx_data_o),
    .done_o     (done_o),
    .tx_oe      (tx_oe),
    .data_io    (data_io)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Device: first released cycle is TURN, then reply byte i in released cycle i+2.
  initial begin
    dev_cyc   = 0;
    dev_drive = 1'b0;
    dev_val   = 8'h00;
    forever begin
      @(posedge clk_i);
      #1;
      if (tx_oe === 1'b1) begin
        dev_cyc = dev_cyc + 1;
        if (dev_cyc >= 2 && dev_cyc <= dev_len + 1) begin
          dev_drive = 1'b1;
          dev_val   = dev_bytes[dev_cyc-2];
        end else begin
          dev_drive = 1'b0;
        end
      end else begin
        dev_cyc   = 0;
        dev_drive = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    tx_valid_i = 1'b1;
    tx_data_i  = b;
    tick();
    tx_valid_i = 1'b0;
  endtask

  task automatic start(input logic [7:0] len);
    start_i  = 1'b1;
    rx_len_i = len;
    tick();
    start_i  = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_ni     = 1'b0;
    tx_valid_i = 1'b0;
    tx_data_i  = 8'h00;
    start_i    = 1'b0;
    rx_len_i   = 8'h00;
    dev_len    = 0;
    for (int i = 0; i < 8; i++) dev_bytes[i] = 8'h00;

    #3;
    chk("rst_tx_oe",    32'(tx_oe),      32'h0);
    chk("rst_data_io",  32'(data_io),    32'h00);
    chk("rst_ready",    32'(tx_ready_o), 32'h1);
    chk("rst_busy",     32'(busy_o),     32'h0);
    chk("rst_rx_valid", 32'(rx_valid_o), 32'h0);
    chk("rst_rx_data",  32'(rx_data_o),  32'h00);
    chk("rst_done",     32'(done_o),     32'h0);
    tick();
    rst_ni = 1'b1;
    tick();

    // TX only: FF, 0F, 01 with no reply
    push(8'hFF);
    push(8'h0F);
    push(8'h01);
    start(8'd0);
    chk("tx0_data", 32'(data_io), 32'hFF);
    chk("tx0_oe",   32'(tx_oe),   32'h0);
    chk("tx0_busy", 32'(busy_o),  32'h1);
    tick();
    chk("tx1_data", 32'(data_io), 32'h0F);
    chk("tx1_done", 32'(done_o),  32'h0);
    tick();
    chk("tx2_data", 32'(data_io), 32'h01);
    chk("tx2_oe",   32'(tx_oe),   32'h0);
    tick();
    chk("txe_data", 32'(data_io), 32'h00);
    chk("txe_done", 32'(done_o),  32'h1);
    chk("txe_busy", 32'(busy_o),  32'h0);
    tick();
    chk("txe_done_clr", 32'(done_o), 32'h0);

    // Round trip: 02, 04 out, 10/20/40/80 back; stray start during RX
    dev_len = 4;
    dev_bytes[0] = 8'h10; dev_bytes[1] = 8'h20; dev_bytes[2] = 8'h40; dev_bytes[3] = 8'h80;
    push(8'h02);
    push(8'h04);
    start(8'd4);
    chk("rt_tx0", 32'(data_io), 32'h02);
    tick();
    chk("rt_tx1",    32'(data_io), 32'h04);
    chk("rt_tx1_oe", 32'(tx_oe),   32'h0);
    tick();
    chk("rt_turn_oe",    32'(tx_oe),      32'h1);
    chk("rt_turn_valid", 32'(rx_valid_o), 32'h0);
    tick();
    chk("rt_rx0_oe",    32'(tx_oe),      32'h1);
    chk("rt_rx0_valid", 32'(rx_valid_o), 32'h0);
    chk("rt_rx0_bus",   32'(data_io),    32'h10);
    start_i  = 1'b1;
    rx_len_i = 8'd7;
    tick();
    start_i  = 1'b0;
    chk("rt_rx_b0_valid", 32'(rx_valid_o), 32'h1);
    chk("rt_rx_b0",       32'(rx_data_o),  32'h10);
    tick();
    chk("rt_rx_b1", 32'(rx_data_o), 32'h20);
    tick();
    chk("rt_rx_b2", 32'(rx_data_o), 32'h40);
    chk("rt_rx_b2_done", 32'(done_o), 32'h0);
    tick();
    chk("rt_tb_valid", 32'(rx_valid_o), 32'h1);
    chk("rt_rx_b3",    32'(rx_data_o),  32'h80);
    chk("rt_tb_oe",    32'(tx_oe),      32'h1);
    chk("rt_tb_busy",  32'(busy_o),     32'h1);
    tick();
    chk("rt_end_oe",    32'(tx_oe),      32'h0);
    chk("rt_end_data",  32'(data_io),    32'h00);
    chk("rt_end_done",  32'(done_o),     32'h1);
    chk("rt_end_valid", 32'(rx_valid_o), 32'h0);
    chk("rt_end_busy",  32'(busy_o),     32'h0);
    tick();
    chk("rt_post_done", 32'(done_o), 32'h0);
    chk("rt_post_busy", 32'(busy_o), 32'h0);

    // RX only: straight to TURN, one capture, three busy cycles
    dev_len = 1;
    dev_bytes[0] = 8'hC3;
    start(8'd1);
    chk("ro_turn_busy", 32'(busy_o), 32'h1);
    chk("ro_turn_oe",   32'(tx_oe),  32'h1);
    tick();
    chk("ro_rx_busy", 32'(busy_o), 32'h1);
    tick();
    chk("ro_tb_busy",  32'(busy_o),     32'h1);
    chk("ro_tb_valid", 32'(rx_valid_o), 32'h1);
    chk("ro_tb_data",  32'(rx_data_o),  32'hC3);
    tick();
    chk("ro_end_busy", 32'(busy_o), 32'h0);
    chk("ro_end_done", 32'(done_o), 32'h1);
    tick();

    // FIFO full: 9 pushes, the 9th dropped; AA pushed during TX waits
    for (int i = 0; i < 9; i++) begin
      push(8'h30 + 8'(i));
      chk($sformatf("full_ready_%0d", i), 32'(tx_ready_o), (i < 7) ? 32'h1 : 32'h0);
    end
    start(8'd0);
    chk("full_tx0", 32'(data_io), 32'h30);
    tx_valid_i = 1'b1;
    tx_data_i  = 8'hAA;
    tick();
    tx_valid_i = 1'b0;
    chk("full_tx1",   32'(data_io),    32'h31);
    chk("full_ready", 32'(tx_ready_o), 32'h1);
    for (int i = 2; i < 8; i++) begin
      tick();
      chk($sformatf("full_tx%0d", i), 32'(data_io), 32'h30 + 32'(i));
    end
    tick();
    chk("full_end_data", 32'(data_io), 32'h00);
    chk("full_end_done", 32'(done_o),  32'h1);
    tick();
    start(8'd0);
    chk("aa_tx0", 32'(data_io), 32'hAA);
    tick();
    chk("aa_end_data", 32'(data_io), 32'h00);
    chk("aa_end_done", 32'(done_o),  32'h1);
    chk("aa_end_busy", 32'(busy_o),  32'h0);
    tick();

    // Reset mid-RX after 3 of 5 captures
    dev_len = 5;
    for (int i = 0; i < 5; i++) dev_bytes[i] = 8'h01 + 8'(i);
    push(8'h77);
    start(8'd5);
    chk("ra_tx0", 32'(data_io), 32'h77);
    push(8'h99);
    tick();
    tick();
    tick();
    tick();
    chk("ra_b2_valid", 32'(rx_valid_o), 32'h1);
    chk("ra_b2",       32'(rx_data_o),  32'h03);
    chk("ra_b2_oe",    32'(tx_oe),      32'h1);
    rst_ni = 1'b0;
    #1;
    chk("ra_oe",    32'(tx_oe),      32'h0);
    chk("ra_data",  32'(data_io),    32'h00);
    chk("ra_busy",  32'(busy_o),     32'h0);
    chk("ra_valid", 32'(rx_valid_o), 32'h0);
    chk("ra_rxd",   32'(rx_data_o),  32'h00);
    chk("ra_done",  32'(done_o),     32'h0);
    chk("ra_ready", 32'(tx_ready_o), 32'h1);
    tick();
    chk("ra_hold_done", 32'(done_o), 32'h0);
    rst_ni = 1'b1;
    tick();
    chk("ra_rel_done", 32'(done_o), 32'h0);
    chk("ra_rel_busy", 32'(busy_o), 32'h0);
    start(8'd0);
    chk("ra_empty_busy", 32'(busy_o),  32'h0);
    chk("ra_empty_done", 32'(done_o),  32'h1);
    chk("ra_empty_data", 32'(data_io), 32'h00);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
